// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline datapath and its stall controller.
// The datapath (master) raises stall/redirect requests; the controller
// (slave) returns per-stage enables, bubbles, PC control and status.
interface pipeline_stall_controller_if #(
  parameter int STAGES        = 5,
  parameter int COUNTER_WIDTH = 32
);

  // Requests from the hazard units, EX, MEM and software
  logic                     hazard_stall;
  logic                     divide_busy;
  logic                     memory_busy;
  logic                     redirect;
  logic                     clear_timeout;

  // Controls and status back to the datapath
  logic [STAGES-1:0]        stage_enable;
  logic [STAGES-1:0]        stage_bubble;
  logic                     pc_enable;
  logic                     pc_select_redirect;
  logic [2:0]               state;
  logic                     stall_timeout;
  logic [COUNTER_WIDTH-1:0] stall_cycles;

  modport master (
    output hazard_stall, divide_busy, memory_busy, redirect, clear_timeout,
    input  stage_enable, stage_bubble, pc_enable, pc_select_redirect,
           state, stall_timeout, stall_cycles
  );

  modport slave (
    input  hazard_stall, divide_busy, memory_busy, redirect, clear_timeout,
    output stage_enable, stage_bubble, pc_enable, pc_select_redirect,
           state, stall_timeout, stall_cycles
  );

endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the five-stage IF/ID/EX/MEM/WB pipeline.
// Decodes the freeze class from the current requests, drives stage enables,
// bubbles and PC control with zero latency, and keeps a stall watchdog and
// a saturating stall-cycle performance counter.
module pipeline_stall_controller #(
  parameter int STAGES        = 5,
  parameter int STALL_LIMIT   = 15,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  pipeline_stall_controller_if.slave    ctrl_if
);

  // Stage bit positions
  localparam int IF_STG  = 0;
  localparam int ID_STG  = 1;
  localparam int EX_STG  = 2;
  localparam int MEM_STG = 3;
  localparam int WB_STG  = 4;

  // FSM encodings (visible on the state output)
  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_STALL_ID  = 3'd1;
  localparam logic [2:0] ST_STALL_EX  = 3'd2;
  localparam logic [2:0] ST_STALL_MEM = 3'd3;
  localparam logic [2:0] ST_FLUSH     = 3'd4;

  // Watchdog counter sizing
  localparam int              FC_W       = $clog2(STALL_LIMIT + 1);
  localparam logic [FC_W-1:0] FC_LIMIT   = FC_W'(STALL_LIMIT);
  localparam logic [FC_W-1:0] FC_TRIGGER = FC_W'(STALL_LIMIT - 1);

  // Registered state
  logic [2:0]               state_q,        state_d;
  logic [FC_W-1:0]          freeze_cnt_q,   freeze_cnt_d;
  logic                     timeout_q,      timeout_d;
  logic [COUNTER_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  // Combinational controls
  logic              eff_hazard;
  logic [STAGES-1:0] enable_d;
  logic [STAGES-1:0] bubble_d;
  logic              pc_enable_d;
  logic              pc_select_d;

  // In FLUSH the ID instruction is a squashed bubble, so its hazard is spurious.
  // Reset forces state_q to RUN, which keeps this filter inactive during reset.
  assign eff_hazard = ctrl_if.hazard_stall & (state_q != ST_FLUSH);

  // Freeze-class decode, highest priority first; also yields the next state
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    enable_d    = '1;
    bubble_d    = '0;
    pc_select_d = 1'b0;
    state_d     = ST_RUN;

    if (ctrl_if.memory_busy) begin
      // MEM access pending: freeze IF..MEM, feed WB a bubble
      enable_d[IF_STG]  = 1'b0;
      enable_d[ID_STG]  = 1'b0;
      enable_d[EX_STG]  = 1'b0;
      enable_d[MEM_STG] = 1'b0;
      bubble_d[WB_STG]  = 1'b1;
      state_d           = ST_STALL_MEM;
    end else if (ctrl_if.divide_busy) begin
      // Multi-cycle EX op: freeze IF..EX, feed MEM a bubble
      enable_d[IF_STG]  = 1'b0;
      enable_d[ID_STG]  = 1'b0;
      enable_d[EX_STG]  = 1'b0;
      bubble_d[MEM_STG] = 1'b1;
      state_d           = ST_STALL_EX;
    end else if (ctrl_if.redirect) begin
      // Taken branch: squash the wrong-path instructions entering ID and EX.
      // Beats the hazard stall because the stalled ID instruction is squashed.
      bubble_d[ID_STG]  = 1'b1;
      bubble_d[EX_STG]  = 1'b1;
      pc_select_d       = 1'b1;
      state_d           = ST_FLUSH;
    end else if (eff_hazard) begin
      // Load-use: hold IF/ID, feed EX a bubble
      enable_d[IF_STG]  = 1'b0;
      enable_d[ID_STG]  = 1'b0;
      bubble_d[EX_STG]  = 1'b1;
      state_d           = ST_STALL_ID;
    end
  end

  // PC follows the IF enable except on a flush, where it always loads the target
  assign pc_enable_d = (state_d == ST_FLUSH) ? 1'b1 : enable_d[IF_STG];

  // Watchdog and performance-counter next-state logic
  always_comb begin
    freeze_cnt_d   = freeze_cnt_q;
    stall_cycles_d = stall_cycles_q;

    if (pc_enable_d) begin
      freeze_cnt_d = '0;
    end else if (freeze_cnt_q != FC_LIMIT) begin
      freeze_cnt_d = freeze_cnt_q + 1'b1;
    end

    if (!pc_enable_d && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // Set wins over a simultaneous clear
    timeout_d = (!pc_enable_d && (freeze_cnt_q == FC_TRIGGER)) ||
                (timeout_q && !ctrl_if.clear_timeout);
  end

  // State, watchdog and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_RUN;
      freeze_cnt_q   <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its neighbours regardless of statement order.
      state_q        <= state_d;
      freeze_cnt_q   <= freeze_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Drive the interface
  assign ctrl_if.stage_enable       = enable_d;
  assign ctrl_if.stage_bubble       = bubble_d;
  assign ctrl_if.pc_enable          = pc_enable_d;
  assign ctrl_if.pc_select_redirect = pc_select_d;
  assign ctrl_if.state              = state_q;
  assign ctrl_if.stall_timeout      = timeout_q;
  assign ctrl_if.stall_cycles       = stall_cycles_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It collects stall requests from the ID-stage hazard units, from the multi-cycle divide unit, and from the data-memory interface, plus the taken-branch redirect from EX. From these it drives per-stage register enables, bubble insertion and the PC write enable. It also keeps a stall-length watchdog and a saturating stall-cycle performance counter.

## Interface
- STAGES, 5, number of pipeline stages; bit index 0 = IF … 4 = WB
- STALL_LIMIT, 15, consecutive frozen cycles after which the watchdog fires
- COUNTER_WIDTH, 32, width of the stall-cycle performance counter
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately
- hazardStall  input  1  OR of ID-stage hazard-unit stall outputs (load-use)
- divideBusy  input  1  multi-cycle unit in EX has not finished
- memoryBusy  input  1  MEM-stage data access not complete
- redirect  input  1  EX resolved a taken branch/jump this cycle
- clearTimeout  input  1  synchronous clear of stallTimeout
- stageEnable  output  STAGES  bit i=1: stage i input register latches at next posedge
- stageBubble  output  STAGES  bit i=1: stage i input register loads a NOP
- pcEnable  output  1  PC register updates at next posedge
- pcSelectRedirect  output  1  PC loads the redirect target, not PC+4
- state  output  3  FSM state: RUN=0, STALL_ID=1, STALL_EX=2, STALL_MEM=3, FLUSH=4
- stallTimeout  output  1  sticky watchdog flag
- stallCycles  output  COUNTER_WIDTH  saturating count of cycles with pcEnable=0

## Operation
- Effective hazard stall is effHazard = hazardStall & (state != FLUSH). In FLUSH the ID instruction is a squashed bubble, so its hazard request is spurious and is ignored.
- The freeze class is decided combinationally from the current inputs, highest priority first:
  - memoryBusy → MEM class: enable[3:0]=0, bubble[4]=1, enable[4]=1.
  - divideBusy → EX class: enable[2:0]=0, bubble[3]=1, enable[4:3]=1.
  - redirect → FLUSH: all enables 1, bubble[1]=1 and bubble[2]=1, pcEnable=1, pcSelectRedirect=1.
  - effHazard → ID class: enable[1:0]=0, bubble[2]=1, enable[4:2]=1.
  - Otherwise → RUN: all enables 1, no bubbles, pcEnable=1.
- Redirect takes priority over hazardStall, because the stalled ID instruction is squashed. Redirect loses to memoryBusy and divideBusy. EX is frozen in that case, so redirect stays asserted and is accepted on the first unfrozen cycle.
- pcEnable = stageEnable[0] in every class except FLUSH, where it is 1.
- stageBubble[i]=1 only when stageEnable[i]=1. No other bubble bits are set.
- Next state at posedge is the class computed that cycle: MEM→STALL_MEM, EX→STALL_EX, FLUSH→FLUSH, ID→STALL_ID, else RUN. FLUSH therefore lasts exactly one cycle after each accepted redirect, unless another redirect follows.
- Outputs depend only on the current inputs and on the FLUSH state. `state` is registered and visible.
- Watchdog:
  - freezeCount, width $clog2(STALL_LIMIT+1), increments on each cycle with pcEnable=0 and saturates at STALL_LIMIT.
  - It clears to 0 on any cycle with pcEnable=1.
  - stallTimeout is set at the posedge where freezeCount is STALL_LIMIT−1 and pcEnable=0.
  - Once set, stallTimeout stays set until clearTimeout=1 or reset. A clear and a set in the same cycle resolve to set.
- stallCycles increments on each pcEnable=0 cycle and saturates at all-ones. It never wraps.

## Timing
- Reset values: state=RUN, freezeCount=0, stallTimeout=0, stallCycles=0. During reset, outputs follow the RUN decode of the inputs, with the FLUSH filter inactive.
- Reset deasserted mid-stall: the first posedge after release starts from RUN and freezeCount=0.
- Combinational latency from inputs to enables, bubbles and PC outputs is 0 cycles.
- State, counter and watchdog outputs change 1 cycle after the causing posedge.
- Stage registers and the PC sample the enables at the same posedge the controller updates its state.

## Test plan
- hazardStall=1 for 2 cycles in RUN → stageEnable=5'b11100 and stageBubble=5'b00100 for both cycles, pcEnable=0, state=STALL_ID then RUN, stallCycles=2.
- divideBusy=1 for 3 cycles with hazardStall=1 → EX class wins: stageEnable=5'b11000, stageBubble=5'b01000, stallCycles=3.
- redirect=1 and hazardStall=1 in the same cycle → FLUSH class: stageBubble=5'b00110, pcSelectRedirect=1. Next cycle hazardStall=1 is ignored (state=FLUSH), giving enable=5'b11111.
- memoryBusy=1 and redirect=1 for 4 cycles, then memoryBusy=0 → 4 cycles of enable=5'b10000; redirect is accepted on cycle 5 with pcSelectRedirect=1.
- memoryBusy held for 20 cycles with STALL_LIMIT=15 → stallTimeout rises after the 15th frozen cycle and stays 1 after memoryBusy drops. clearTimeout=1 clears it next cycle.
- Assert reset (0) asynchronously in STALL_MEM with stallCycles=7 → state=RUN and stallCycles=0 immediately, without waiting for a clock edge.
